// File: rtl/vsync_timing_receiver.sv
// Vertical timing receiver: synchronises active-low hsync/vsync, measures frame timing,
// locks to the expected values and recovers yposition. Optional: VSYNC_RX_LOSS_COUNT_EN.
module vsync_timing_receiver #(
    parameter int unsigned yresolution = 10,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [yresolution-1:0] ActiveVideo,
    input  logic [yresolution-1:0] FrontPorch,
    input  logic [yresolution-1:0] SynchPulse,
    input  logic [yresolution-1:0] BackPorch,
    output logic [yresolution-1:0] yposition,
    output logic                   ActiveLine,
    output logic                   FrameStart,
    output logic                   Locked,
    output logic [yresolution-1:0] MeasTotal,
    output logic [yresolution-1:0] MeasSync,
    output logic [7:0]             LockLossCnt
);

    localparam int unsigned YW = yresolution;
    localparam logic [YW-1:0] LcMax = '1;
    localparam logic [YW-1:0] LcOne = YW'(1);
    localparam logic [YW:0] One = (YW + 1)'(1);
    localparam logic [3:0] LockTarget = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    state_e        state_q;
    logic          hs_s1_q, hs_s2_q, hs_h_q;
    logic          vs_s1_q, vs_s2_q, vs_h_q;
    logic [YW-1:0] lc_q, lc_d, sc_q, ypos_q, y_d;
    logic [YW-1:0] meas_total_q, meas_sync_q;
    logic          sync_ok_q, locked_q, active_q, frame_start_q;
    logic [3:0]    match_cnt_q;

    logic          line_strobe, v_fall, v_rise, lc_sat, match, lock_evt, locked_nxt;
    logic          active_d, frame_start_d;
    logic [YW:0]   total, exp_sync, meas_val;
    logic [YW+1:0] y_full;

    always_comb begin
        line_strobe = hs_h_q & ~hs_s2_q;
        v_fall      = vs_h_q & ~vs_s2_q;
        v_rise      = ~vs_h_q & vs_s2_q;
        total       = {1'b0, ActiveVideo} + {1'b0, FrontPorch} + {1'b0, SynchPulse}
                    + {1'b0, BackPorch} + One;
        exp_sync    = {1'b0, SynchPulse} + One;
        // A line strobe coinciding with VFall still belongs to the ending frame.
        meas_val    = {1'b0, lc_q} + {{YW{1'b0}}, line_strobe};
        match       = sync_ok_q && (meas_val == total);
        lc_sat      = (lc_q == LcMax);

        lc_d = lc_q;
        if (v_fall) begin
            lc_d = '0;
        end else if (line_strobe && !lc_sat) begin
            lc_d = lc_q + LcOne;
        end

        lock_evt = (state_q == StMeasure) && v_fall && match
                && ((match_cnt_q + 4'd1) >= LockTarget);

        if (lc_sat && !v_fall) begin
            locked_nxt = 1'b0;
        end else if (state_q == StLocked) begin
            locked_nxt = !(v_fall && !match);
        end else begin
            locked_nxt = lock_evt;
        end

        // Line counter restarts at VFall, which the transmitter places at line AV+FP.
        y_full = {2'b0, ActiveVideo} + {2'b0, FrontPorch} + {2'b0, lc_d};
        y_d = '0;
        if (locked_nxt) begin
            y_d = (y_full >= {1'b0, total}) ? YW'(y_full - {1'b0, total}) : YW'(y_full);
        end
        active_d      = locked_nxt && (y_d < ActiveVideo);
        frame_start_d = locked_nxt && (y_d == '0) && ({1'b0, ypos_q} == (total - One));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hs_s1_q       <= 1'b1;
            hs_s2_q       <= 1'b1;
            hs_h_q        <= 1'b1;
            vs_s1_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            vs_h_q        <= 1'b1;
            state_q       <= StSearch;
            lc_q          <= '0;
            sc_q          <= '0;
            sync_ok_q     <= 1'b0;
            meas_total_q  <= '0;
            meas_sync_q   <= '0;
            match_cnt_q   <= 4'd0;
            locked_q      <= 1'b0;
            ypos_q        <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hs_s1_q <= hsync_in;
            hs_s2_q <= hs_s1_q;
            hs_h_q  <= hs_s2_q;
            vs_s1_q <= vsync_in;
            vs_s2_q <= vs_s1_q;
            vs_h_q  <= vs_s2_q;

            lc_q <= lc_d;
            if (v_fall) begin
                sc_q <= '0;
            end else if (line_strobe && !vs_s2_q && (sc_q != LcMax)) begin
                sc_q <= sc_q + LcOne;
            end

            if (v_rise) begin
                meas_sync_q <= sc_q;
                sync_ok_q   <= ({1'b0, sc_q} == exp_sync);
            end else if (v_fall) begin
                sync_ok_q <= 1'b0;
            end
            if (v_fall) begin
                meas_total_q <= YW'(meas_val);
            end

            if (lc_sat && !v_fall) begin
                state_q     <= StSearch;
                match_cnt_q <= 4'd0;
            end else begin
                case (state_q)
                    StSearch: begin
                        if (v_fall) begin
                            state_q     <= StMeasure;
                            match_cnt_q <= 4'd0;
                        end
                    end
                    StMeasure: begin
                        if (v_fall) begin
                            if (match) begin
                                match_cnt_q <= match_cnt_q + 4'd1;
                                if (lock_evt) begin
                                    state_q <= StLocked;
                                end
                            end else begin
                                match_cnt_q <= 4'd0;
                            end
                        end
                    end
                    StLocked: begin
                        if (v_fall && !match) begin
                            state_q     <= StMeasure;
                            match_cnt_q <= 4'd0;
                        end
                    end
                    default: begin
                        state_q     <= StSearch;
                        match_cnt_q <= 4'd0;
                    end
                endcase
            end

            locked_q      <= locked_nxt;
            ypos_q        <= y_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VSYNC_RX_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            loss_cnt_q <= 8'd0;
        end else if ((state_q == StLocked) && !locked_nxt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign LockLossCnt = loss_cnt_q;
`else
    assign LockLossCnt = 8'd0;
`endif

    assign yposition  = ypos_q;
    assign ActiveLine = active_q;
    assign FrameStart = frame_start_q;
    assign Locked     = locked_q;
    assign MeasTotal  = meas_total_q;
    assign MeasSync   = meas_sync_q;

endmodule
